// File: rtl/mips_decode_alu_if.sv
// Bundle of the decode/ALU slice: instruction and operands in, registered
// control, ALU result and branch decision out.
interface mips_decode_alu_if #(
    parameter int XLEN = 32
);
    logic [31:0]     inst;
    logic [XLEN-1:0] rs_data;
    logic [XLEN-1:0] rt_data;
    logic [XLEN-1:0] alu_result;
    logic            zero;
    logic            overflow;
    logic            reg_dst;
    logic [1:0]      alu_src;
    logic            mem_to_reg;
    logic            mem_read;
    logic            mem_write;
    logic            reg_write;
    logic            is_byte;
    logic [2:0]      branch;
    logic            branch_taken;
    logic [1:0]      jump;
    logic            jr;
    logic            do_extend;
    logic [3:0]      alu_ctrl;
    logic            illegal;
    logic            halted;

    modport master (
        output inst, rs_data, rt_data,
        input  alu_result, zero, overflow, reg_dst, alu_src, mem_to_reg,
               mem_read, mem_write, reg_write, is_byte, branch, branch_taken,
               jump, jr, do_extend, alu_ctrl, illegal, halted
    );

    modport slave (
        input  inst, rs_data, rt_data,
        output alu_result, zero, overflow, reg_dst, alu_src, mem_to_reg,
               mem_read, mem_write, reg_write, is_byte, branch, branch_taken,
               jump, jr, do_extend, alu_ctrl, illegal, halted
    );
endinterface

// File: rtl/mips_decode_alu.sv
// Decode-and-execute slice of the single-cycle MIPS core: main decoder,
// ALU-control decoder and 32-bit ALU, all outputs registered once.
// Optional feature macro: ALU_OVERFLOW_EN (signed ADD/SUB overflow flag and
// write-back suppression); without it overflow is tied to 0.
module mips_decode_alu #(
    parameter int XLEN = 32
) (
    input logic             clk,
    input logic             rst,
    mips_decode_alu_if.slave bus
);
    localparam logic [3:0] ALU_AND  = 4'd0;
    localparam logic [3:0] ALU_OR   = 4'd1;
    localparam logic [3:0] ALU_ADD  = 4'd2;
    localparam logic [3:0] ALU_XOR  = 4'd3;
    localparam logic [3:0] ALU_NOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SUB  = 4'd6;
    localparam logic [3:0] ALU_SLT  = 4'd7;
    localparam logic [3:0] ALU_SLTU = 4'd8;
    localparam logic [3:0] ALU_SRL  = 4'd9;
    localparam logic [3:0] ALU_SRA  = 4'd10;
    localparam logic [3:0] ALU_LUI  = 4'd11;

    function automatic logic [XLEN-1:0] alu_fn(input logic [3:0] op,
                                               input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
        logic [XLEN-1:0] r;
        case (op)
            ALU_AND:  r = a & b;
            ALU_OR:   r = a | b;
            ALU_ADD:  r = a + b;
            ALU_XOR:  r = a ^ b;
            ALU_NOR:  r = ~(a | b);
            ALU_SLL:  r = b << a[4:0];
            ALU_SUB:  r = a - b;
            ALU_SLT:  r = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: r = {{(XLEN-1){1'b0}}, (a < b)};
            ALU_SRL:  r = b >> a[4:0];
            ALU_SRA:  r = $unsigned($signed(b) >>> a[4:0]);
            ALU_LUI:  r = {b[15:0], {(XLEN-16){1'b0}}};
            default:  r = '0;
        endcase
        return r;
    endfunction

    // Signed overflow: operands (B inverted for SUB) agree in sign, result does not.
    function automatic logic ovf_fn(input logic [3:0] op, input logic [XLEN-1:0] a,
                                    input logic [XLEN-1:0] b, input logic [XLEN-1:0] r);
        logic bs;
        bs = (op == ALU_SUB) ? ~b[XLEN-1] : b[XLEN-1];
        return (a[XLEN-1] == bs) && (r[XLEN-1] != a[XLEN-1]);
    endfunction

    logic [5:0] opcode_p0, func_p0;
    logic [4:0] rt_p0, shamt_p0;
    logic [15:0] imm_p0;
    logic       unused_rs_field;

    assign opcode_p0       = bus.inst[31:26];
    assign rt_p0           = bus.inst[20:16];
    assign shamt_p0        = bus.inst[10:6];
    assign func_p0         = bus.inst[5:0];
    assign imm_p0          = bus.inst[15:0];
    assign unused_rs_field = ^bus.inst[25:21];

    logic       reg_dst_p0, mem_to_reg_p0, mem_read_p0, mem_write_p0, reg_write_p0;
    logic       is_byte_p0, jr_p0, do_extend_p0, illegal_p0, halt_p0, ovf_chk_p0;
    logic [1:0] alu_src_p0, jump_p0;
    logic [2:0] branch_p0;
    logic [3:0] alu_ctrl_p0;

    // Main decoder and ALU-control decoder.
    always_comb begin
        reg_dst_p0    = 1'b0;
        alu_src_p0    = 2'b00;
        mem_to_reg_p0 = 1'b0;
        mem_read_p0   = 1'b0;
        mem_write_p0  = 1'b0;
        reg_write_p0  = 1'b0;
        is_byte_p0    = 1'b0;
        branch_p0     = 3'd0;
        jump_p0       = 2'b00;
        jr_p0         = 1'b0;
        do_extend_p0  = 1'b0;
        alu_ctrl_p0   = ALU_ADD;
        illegal_p0    = 1'b0;
        halt_p0       = 1'b0;
        ovf_chk_p0    = 1'b0;
        case (opcode_p0)
            6'h00: begin
                reg_dst_p0   = 1'b1;
                reg_write_p0 = 1'b1;
                case (func_p0)
                    6'h20: begin alu_ctrl_p0 = ALU_ADD; ovf_chk_p0 = 1'b1; end
                    6'h21: alu_ctrl_p0 = ALU_ADD;
                    6'h22: begin alu_ctrl_p0 = ALU_SUB; ovf_chk_p0 = 1'b1; end
                    6'h23: alu_ctrl_p0 = ALU_SUB;
                    6'h24: alu_ctrl_p0 = ALU_AND;
                    6'h25: alu_ctrl_p0 = ALU_OR;
                    6'h26: alu_ctrl_p0 = ALU_XOR;
                    6'h27: alu_ctrl_p0 = ALU_NOR;
                    6'h2A: alu_ctrl_p0 = ALU_SLT;
                    6'h2B: alu_ctrl_p0 = ALU_SLTU;
                    6'h00: begin alu_ctrl_p0 = ALU_SLL; alu_src_p0 = 2'b01; end
                    6'h02: begin alu_ctrl_p0 = ALU_SRL; alu_src_p0 = 2'b01; end
                    6'h03: begin alu_ctrl_p0 = ALU_SRA; alu_src_p0 = 2'b01; end
                    6'h04: alu_ctrl_p0 = ALU_SLL;
                    6'h06: alu_ctrl_p0 = ALU_SRL;
                    6'h07: alu_ctrl_p0 = ALU_SRA;
                    6'h08: begin jr_p0 = 1'b1; reg_write_p0 = 1'b0; end
                    6'h0C: begin halt_p0 = 1'b1; reg_write_p0 = 1'b0; end
                    default: begin illegal_p0 = 1'b1; reg_write_p0 = 1'b0; end
                endcase
            end
            6'h08, 6'h09: begin
                alu_src_p0 = 2'b10; reg_write_p0 = 1'b1; do_extend_p0 = 1'b1;
                ovf_chk_p0 = (opcode_p0 == 6'h08);
            end
            6'h0A: begin alu_src_p0 = 2'b10; reg_write_p0 = 1'b1; do_extend_p0 = 1'b1; alu_ctrl_p0 = ALU_SLT;  end
            6'h0B: begin alu_src_p0 = 2'b10; reg_write_p0 = 1'b1; do_extend_p0 = 1'b1; alu_ctrl_p0 = ALU_SLTU; end
            6'h0C: begin alu_src_p0 = 2'b10; reg_write_p0 = 1'b1; alu_ctrl_p0 = ALU_AND; end
            6'h0D: begin alu_src_p0 = 2'b10; reg_write_p0 = 1'b1; alu_ctrl_p0 = ALU_OR;  end
            6'h0E: begin alu_src_p0 = 2'b10; reg_write_p0 = 1'b1; alu_ctrl_p0 = ALU_XOR; end
            6'h0F: begin alu_src_p0 = 2'b10; reg_write_p0 = 1'b1; alu_ctrl_p0 = ALU_LUI; end
            6'h23, 6'h20: begin
                alu_src_p0 = 2'b10; reg_write_p0 = 1'b1; do_extend_p0 = 1'b1;
                mem_read_p0 = 1'b1; mem_to_reg_p0 = 1'b1; is_byte_p0 = (opcode_p0 == 6'h20);
            end
            6'h2B, 6'h28: begin
                alu_src_p0 = 2'b10; do_extend_p0 = 1'b1; mem_write_p0 = 1'b1;
                is_byte_p0 = (opcode_p0 == 6'h28);
            end
            6'h04, 6'h05, 6'h06, 6'h07: begin
                alu_ctrl_p0 = ALU_SUB; do_extend_p0 = 1'b1;
                branch_p0 = opcode_p0[2:0] - 3'd3;
            end
            6'h01: begin
                if (rt_p0 == 5'd0 || rt_p0 == 5'd1) begin
                    alu_ctrl_p0 = ALU_SUB; do_extend_p0 = 1'b1;
                    branch_p0 = (rt_p0 == 5'd0) ? 3'd5 : 3'd6;
                end else begin
                    illegal_p0 = 1'b1;
                end
            end
            6'h02: jump_p0 = 2'b01;
            6'h03: begin jump_p0 = 2'b10; reg_write_p0 = 1'b1; end
            default: illegal_p0 = 1'b1;
        endcase
    end

    logic [XLEN-1:0] ext_imm_p0, op_a_p0, op_b_p0, result_p0;
    logic            taken_p0, ovf_p0, rs_zero_p0;

    assign ext_imm_p0 = do_extend_p0 ? {{(XLEN-16){imm_p0[15]}}, imm_p0}
                                     : {{(XLEN-16){1'b0}}, imm_p0};
    assign op_a_p0    = alu_src_p0[0] ? {{(XLEN-5){1'b0}}, shamt_p0} : bus.rs_data;
    assign op_b_p0    = alu_src_p0[1] ? ext_imm_p0 : bus.rt_data;
    assign result_p0  = alu_fn(alu_ctrl_p0, op_a_p0, op_b_p0);
    assign rs_zero_p0 = (bus.rs_data == '0);

`ifdef ALU_OVERFLOW_EN
    assign ovf_p0 = ovf_chk_p0 && ovf_fn(alu_ctrl_p0, op_a_p0, op_b_p0, result_p0);
`else
    logic unused_ovf_chk;
    assign unused_ovf_chk = ovf_chk_p0;
    assign ovf_p0         = 1'b0;
`endif

    // Branch condition evaluated on the raw register operands.
    always_comb begin
        taken_p0 = 1'b0;
        case (branch_p0)
            3'd1: taken_p0 = (bus.rs_data == bus.rt_data);
            3'd2: taken_p0 = (bus.rs_data != bus.rt_data);
            3'd3: taken_p0 = bus.rs_data[XLEN-1] || rs_zero_p0;
            3'd4: taken_p0 = !bus.rs_data[XLEN-1] && !rs_zero_p0;
            3'd5: taken_p0 = bus.rs_data[XLEN-1];
            3'd6: taken_p0 = !bus.rs_data[XLEN-1];
            default: taken_p0 = 1'b0;
        endcase
    end

    // Output register; the sticky halt blocks architectural writes after SYSCALL.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.alu_result   <= '0;
            bus.zero         <= 1'b0;
            bus.overflow     <= 1'b0;
            bus.reg_dst      <= 1'b0;
            bus.alu_src      <= 2'b00;
            bus.mem_to_reg   <= 1'b0;
            bus.mem_read     <= 1'b0;
            bus.mem_write    <= 1'b0;
            bus.reg_write    <= 1'b0;
            bus.is_byte      <= 1'b0;
            bus.branch       <= 3'd0;
            bus.branch_taken <= 1'b0;
            bus.jump         <= 2'b00;
            bus.jr           <= 1'b0;
            bus.do_extend    <= 1'b0;
            bus.alu_ctrl     <= 4'd0;
            bus.illegal      <= 1'b0;
            bus.halted       <= 1'b0;
        end else begin
            bus.alu_result   <= result_p0;
            bus.zero         <= (result_p0 == '0);
            bus.overflow     <= ovf_p0;
            bus.reg_dst      <= reg_dst_p0;
            bus.alu_src      <= alu_src_p0;
            bus.mem_to_reg   <= mem_to_reg_p0;
            bus.mem_read     <= mem_read_p0;
            bus.mem_write    <= mem_write_p0 && !bus.halted;
            bus.reg_write    <= reg_write_p0 && !bus.halted && !ovf_p0;
            bus.is_byte      <= is_byte_p0;
            bus.branch       <= branch_p0;
            bus.branch_taken <= taken_p0;
            bus.jump         <= jump_p0;
            bus.jr           <= jr_p0;
            bus.do_extend    <= do_extend_p0;
            bus.alu_ctrl     <= alu_ctrl_p0;
            bus.illegal      <= illegal_p0;
            bus.halted       <= bus.halted || halt_p0;
        end
    end
endmodule

// File: tb/tb_mips_decode_alu.sv
// Table-driven bench for mips_decode_alu, plus reset and halt sequences.
module tb_mips_decode_alu;
`ifdef ALU_OVERFLOW_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mips_decode_alu_if #(.XLEN(32)) bus ();
    mips_decode_alu #(.XLEN(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        string       name;
        logic [31:0] inst;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] res;
        logic [20:0] ctrl;
        logic        ovf;
    } vec_t;

    vec_t vecs[64];
    int   nv = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    logic [20:0] act_ctrl;
    assign act_ctrl = {bus.reg_dst, bus.alu_src, bus.mem_to_reg, bus.mem_read,
                       bus.mem_write, bus.reg_write, bus.is_byte, bus.branch,
                       bus.branch_taken, bus.jump, bus.jr, bus.do_extend,
                       bus.alu_ctrl, bus.illegal};

    function automatic logic [20:0] ctl(input logic rd, input logic [1:0] src,
        input logic m2r, input logic mr, input logic mw, input logic rw,
        input logic byt, input logic [2:0] br, input logic bt, input logic [1:0] j,
        input logic jr, input logic ext, input logic [3:0] ac, input logic ill);
        return {rd, src, m2r, mr, mw, rw, byt, br, bt, j, jr, ext, ac, ill};
    endfunction

    function automatic logic [31:0] rtype(input logic [4:0] shamt, input logic [5:0] func);
        return {6'h00, 5'd1, 5'd2, 5'd3, shamt, func};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rt,
                                          input logic [15:0] imm);
        return {op, 5'd1, rt, imm};
    endfunction

    task automatic add(input string name, input logic [31:0] inst, input logic [31:0] rs,
                       input logic [31:0] rt, input logic [31:0] res,
                       input logic [20:0] ctrl, input logic ovf);
        vecs[nv].name = name; vecs[nv].inst = inst; vecs[nv].rs = rs;
        vecs[nv].rt = rt; vecs[nv].res = res; vecs[nv].ctrl = ctrl; vecs[nv].ovf = ovf;
        nv = nv + 1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Drive one instruction, let it register, and compare every output.
    task automatic apply(input string name, input logic [31:0] inst, input logic [31:0] rs,
                         input logic [31:0] rt, input logic [31:0] res, input logic zero,
                         input logic [20:0] ctrl, input logic ovf, input logic halted);
        bus.inst = inst; bus.rs_data = rs; bus.rt_data = rt;
        @(posedge clk);
        #1;
        check({name, ".result"},   bus.alu_result, res);
        check({name, ".zero"},     {31'd0, bus.zero}, {31'd0, zero});
        check({name, ".ctrl"},     {11'd0, act_ctrl}, {11'd0, ctrl});
        check({name, ".overflow"}, {31'd0, bus.overflow}, {31'd0, ovf});
        check({name, ".halted"},   {31'd0, bus.halted}, {31'd0, halted});
    endtask

    initial begin
        //                 rd src m2r mr mw rw byt br bt j jr ext ac ill
        add("sll0",  32'h0, 0, 0, 0,                     ctl(1,1,0,0,0,1,0,0,0,0,0,0,5,0), 0);
        add("add",   rtype(0,6'h20), 5, 7, 12,           ctl(1,0,0,0,0,1,0,0,0,0,0,0,2,0), 0);
        add("addu_wrap", rtype(0,6'h21), 32'h7FFFFFFF, 1, 32'h80000000,
                                                         ctl(1,0,0,0,0,1,0,0,0,0,0,0,2,0), 0);
        add("add_ovf", rtype(0,6'h20), 32'h7FFFFFFF, 1, 32'h80000000,
                                                         ctl(1,0,0,0,0,!OVF_EN,0,0,0,0,0,0,2,0), OVF_EN);
        add("sub",   rtype(0,6'h22), 5, 7, 32'hFFFFFFFE, ctl(1,0,0,0,0,1,0,0,0,0,0,0,6,0), 0);
        add("sub_ovf", rtype(0,6'h22), 32'h80000000, 1, 32'h7FFFFFFF,
                                                         ctl(1,0,0,0,0,!OVF_EN,0,0,0,0,0,0,6,0), OVF_EN);
        add("subu",  rtype(0,6'h23), 32'h80000000, 1, 32'h7FFFFFFF,
                                                         ctl(1,0,0,0,0,1,0,0,0,0,0,0,6,0), 0);
        add("slt",   rtype(0,6'h2A), 5, 7, 1,            ctl(1,0,0,0,0,1,0,0,0,0,0,0,7,0), 0);
        add("slt_neg", rtype(0,6'h2A), 32'hFFFFFFFF, 1, 1, ctl(1,0,0,0,0,1,0,0,0,0,0,0,7,0), 0);
        add("sltu",  rtype(0,6'h2B), 32'hFFFFFFFF, 1, 0, ctl(1,0,0,0,0,1,0,0,0,0,0,0,8,0), 0);
        add("and",   rtype(0,6'h24), 32'hF0F0, 32'hFF00, 32'hF000, ctl(1,0,0,0,0,1,0,0,0,0,0,0,0,0), 0);
        add("or",    rtype(0,6'h25), 32'hF0F0, 32'h0F0F, 32'hFFFF, ctl(1,0,0,0,0,1,0,0,0,0,0,0,1,0), 0);
        add("xor",   rtype(0,6'h26), 32'hFF, 32'h0F, 32'hF0, ctl(1,0,0,0,0,1,0,0,0,0,0,0,3,0), 0);
        add("nor",   rtype(0,6'h27), 0, 0, 32'hFFFFFFFF, ctl(1,0,0,0,0,1,0,0,0,0,0,0,4,0), 0);
        add("sra",   rtype(4,6'h03), 32'h12345678, 32'h80000000, 32'hF8000000,
                                                         ctl(1,1,0,0,0,1,0,0,0,0,0,0,10,0), 0);
        add("srl",   rtype(4,6'h02), 32'h12345678, 32'h80000000, 32'h08000000,
                                                         ctl(1,1,0,0,0,1,0,0,0,0,0,0,9,0), 0);
        add("sllv",  rtype(0,6'h04), 32'h24, 1, 32'h10, ctl(1,0,0,0,0,1,0,0,0,0,0,0,5,0), 0);
        add("srav",  rtype(0,6'h07), 8, 32'h80000000, 32'hFF800000,
                                                         ctl(1,0,0,0,0,1,0,0,0,0,0,0,10,0), 0);
        add("lui",   itype(6'h0F,0,16'h1234), 0, 0, 32'h12340000, ctl(0,2,0,0,0,1,0,0,0,0,0,0,11,0), 0);
        add("ori",   itype(6'h0D,0,16'h8000), 0, 0, 32'h8000, ctl(0,2,0,0,0,1,0,0,0,0,0,0,1,0), 0);
        add("andi",  itype(6'h0C,0,16'hFFFF), 32'hFFFF0F0F, 0, 32'h0F0F, ctl(0,2,0,0,0,1,0,0,0,0,0,0,0,0), 0);
        add("xori",  itype(6'h0E,0,16'h00FF), 32'h0F, 0, 32'hF0, ctl(0,2,0,0,0,1,0,0,0,0,0,0,3,0), 0);
        add("addi",  itype(6'h08,0,16'hFFFF), 1, 0, 0, ctl(0,2,0,0,0,1,0,0,0,0,0,1,2,0), 0);
        add("addi_ovf", itype(6'h08,0,16'h0001), 32'h7FFFFFFF, 0, 32'h80000000,
                                                         ctl(0,2,0,0,0,!OVF_EN,0,0,0,0,0,1,2,0), OVF_EN);
        add("addiu", itype(6'h09,0,16'h0001), 32'h7FFFFFFF, 0, 32'h80000000,
                                                         ctl(0,2,0,0,0,1,0,0,0,0,0,1,2,0), 0);
        add("slti",  itype(6'h0A,0,16'hFFFF), 0, 0, 0, ctl(0,2,0,0,0,1,0,0,0,0,0,1,7,0), 0);
        add("sltiu", itype(6'h0B,0,16'hFFFF), 5, 0, 1, ctl(0,2,0,0,0,1,0,0,0,0,0,1,8,0), 0);
        add("lw",    itype(6'h23,0,16'hFFFC), 32'h100, 0, 32'hFC, ctl(0,2,1,1,0,1,0,0,0,0,0,1,2,0), 0);
        add("lb",    itype(6'h20,0,16'h0001), 32'h10, 0, 32'h11, ctl(0,2,1,1,0,1,1,0,0,0,0,1,2,0), 0);
        add("sw",    itype(6'h2B,0,16'h0008), 32'h100, 0, 32'h108, ctl(0,2,0,0,1,0,0,0,0,0,0,1,2,0), 0);
        add("sb",    itype(6'h28,0,16'h0004), 32'h200, 0, 32'h204, ctl(0,2,0,0,1,0,1,0,0,0,0,1,2,0), 0);
        add("beq",   itype(6'h04,0,16'h0010), 9, 9, 0, ctl(0,0,0,0,0,0,0,1,1,0,0,1,6,0), 0);
        add("bne_nt", itype(6'h05,0,16'h0010), 9, 9, 0, ctl(0,0,0,0,0,0,0,2,0,0,0,1,6,0), 0);
        add("bne_t", itype(6'h05,0,16'h0010), 9, 4, 5, ctl(0,0,0,0,0,0,0,2,1,0,0,1,6,0), 0);
        add("blez_t", itype(6'h06,0,16'h0010), 0, 0, 0, ctl(0,0,0,0,0,0,0,3,1,0,0,1,6,0), 0);
        add("blez_nt", itype(6'h06,0,16'h0010), 1, 0, 1, ctl(0,0,0,0,0,0,0,3,0,0,0,1,6,0), 0);
        add("bgtz_t", itype(6'h07,0,16'h0010), 3, 0, 3, ctl(0,0,0,0,0,0,0,4,1,0,0,1,6,0), 0);
        add("bgtz_nt", itype(6'h07,0,16'h0010), 32'h80000000, 0, 32'h80000000,
                                                         ctl(0,0,0,0,0,0,0,4,0,0,0,1,6,0), 0);
        add("bltz",  itype(6'h01,0,16'h0010), 32'h80000000, 0, 32'h80000000,
                                                         ctl(0,0,0,0,0,0,0,5,1,0,0,1,6,0), 0);
        add("bgez_nt", itype(6'h01,1,16'h0010), 32'h80000000, 0, 32'h80000000,
                                                         ctl(0,0,0,0,0,0,0,6,0,0,0,1,6,0), 0);
        add("bgez_t", itype(6'h01,1,16'h0010), 0, 0, 0, ctl(0,0,0,0,0,0,0,6,1,0,0,1,6,0), 0);
        add("regimm_bad", itype(6'h01,2,16'h0010), 1, 2, 3, ctl(0,0,0,0,0,0,0,0,0,0,0,0,2,1), 0);
        add("j",     itype(6'h02,0,16'h0040), 0, 0, 0, ctl(0,0,0,0,0,0,0,0,0,1,0,0,2,0), 0);
        add("jal",   itype(6'h03,0,16'h0040), 0, 0, 0, ctl(0,0,0,0,0,1,0,0,0,2,0,0,2,0), 0);
        add("jr",    rtype(0,6'h08), 32'h40, 0, 32'h40, ctl(1,0,0,0,0,0,0,0,0,0,1,0,2,0), 0);
        add("bad_func", rtype(0,6'h3F), 1, 1, 2, ctl(1,0,0,0,0,0,0,0,0,0,0,0,2,1), 0);
        add("bad_op", itype(6'h3F,0,16'h0000), 2, 3, 5, ctl(0,0,0,0,0,0,0,0,0,0,0,0,2,1), 0);

        // Reset held two cycles with a live ADD on the inputs.
        rst = 1'b1;
        apply("rst0", rtype(0,6'h20), 5, 7, 0, 0, '0, 0, 0);
        apply("rst1", rtype(0,6'h20), 5, 7, 0, 0, '0, 0, 0);
        rst = 1'b0;

        for (int i = 0; i < nv; i++)
            apply(vecs[i].name, vecs[i].inst, vecs[i].rs, vecs[i].rt, vecs[i].res,
                  (vecs[i].res == 32'd0), vecs[i].ctrl, vecs[i].ovf, 1'b0);

        // SYSCALL halts; later writes are blocked until reset.
        apply("syscall", rtype(0,6'h0C), 5, 7, 12, 0, ctl(1,0,0,0,0,0,0,0,0,0,0,0,2,0), 0, 1);
        apply("halt_add", rtype(0,6'h20), 5, 7, 12, 0, ctl(1,0,0,0,0,0,0,0,0,0,0,0,2,0), 0, 1);
        apply("halt_add2", rtype(0,6'h21), 1, 1, 2, 0, ctl(1,0,0,0,0,0,0,0,0,0,0,0,2,0), 0, 1);
        apply("halt_sw", itype(6'h2B,0,16'h0008), 32'h100, 0, 32'h108, 0,
              ctl(0,2,0,0,0,0,0,0,0,0,0,1,2,0), 0, 1);
        rst = 1'b1;
        apply("rst_vs_syscall", rtype(0,6'h0C), 5, 7, 0, 0, '0, 0, 0);
        rst = 1'b0;
        apply("post_rst_add", rtype(0,6'h20), 5, 7, 12, 0, ctl(1,0,0,0,0,1,0,0,0,0,0,0,2,0), 0, 0);
        apply("post_rst_sw", itype(6'h2B,0,16'h0008), 32'h100, 0, 32'h108, 0,
              ctl(0,2,0,0,1,0,0,0,0,0,0,1,2,0), 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
